avm_uart_responder: RTL

AVM_UART_RESPONDER -- requirements
Module: avm_uart_responder

---
 rtl/avm_uart_responder.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/avm_uart_responder.sv
// uart_fifo: generic synchronous FIFO with registered occupancy count.
// Latency: a pushed word is visible at the head on the cycle after the push edge.
// Backpressure: none internally; the caller must only push when there is room or a same-cycle pop.
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     avm_clk,
  input  logic                     avm_rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge avm_clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
endmodule

// avm_uart_responder: Avalon-MM slave exposing an RX FIFO, a TX FIFO and a status word.
// Latency: every bus access takes WAIT_CYCLES+1 cycles; FIFO side effects land at ACK exit.
// Backpressure: waitrequest stalls the master; rx_in_ready drops when RX is full, TX drains on tx_out_ready.
module avm_uart_responder #(
  parameter int FIFO_DEPTH  = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        avm_clk,
  input  logic        avm_rst,
  input  logic [4:0]  avm_address,
  input  logic        avm_read,
  input  logic        avm_write,
  input  logic [31:0] avm_writedata,
  output logic [31:0] avm_readdata,
  output logic        avm_waitrequest,
  input  logic [7:0]  rx_in_data,
  input  logic        rx_in_valid,
  output logic        rx_in_ready,
  output logic [7:0]  tx_out_data,
  output logic        tx_out_valid,
  input  logic        tx_out_ready
);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'((WAIT_CYCLES >= 2) ? (WAIT_CYCLES - 2) : 0);
  localparam logic [4:0] ADDR_RX   = 5'd0;
  localparam logic [4:0] ADDR_TX   = 5'd4;
  localparam logic [4:0] ADDR_STAT = 5'd8;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t          state_q, state_d;
  logic [WCW-1:0]  cnt_q, cnt_d;
  logic [4:0]      addr_q;
  logic            is_wr_q;
  logic            rx_pop_pend_q;
  logic            ur_pend_q;
  logic            clr_pend_q;
  logic            rx_underrun_q;
  logic            tx_overrun_q;

  logic [CW-1:0]   rx_count, tx_count;
  logic [7:0]      rx_head, tx_head;
  logic            rx_full, rx_nonempty, tx_full, tx_not_full;
  logic            rx_push, rx_pop, tx_push, tx_pop, tx_wr, tx_drop;
  logic            load_en, ack_exit;
  logic [4:0]      acc_addr;
  logic            acc_wr;
  logic [31:0]     rd_next;
  logic            unused_wdat;

  assign unused_wdat = ^avm_writedata[31:8];

  assign rx_full     = (rx_count == CW'(FIFO_DEPTH));
  assign rx_nonempty = (rx_count != '0);
  assign tx_full     = (tx_count == CW'(FIFO_DEPTH));
  assign tx_not_full = !tx_full;

  // Next-state logic for the bus handshake; waitrequest low only in ACK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (avm_read || avm_write) begin
          if (WAIT_CYCLES == 1) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!avm_read && !avm_write) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign avm_waitrequest = (state_q != ST_ACK);
  assign load_en  = (state_d == ST_ACK) && (state_q != ST_ACK);
  assign ack_exit = (state_q == ST_ACK);

  // With a single wait cycle ACK is entered straight from IDLE, before the latch holds the access.
  assign acc_addr = (state_q == ST_IDLE) ? avm_address : addr_q;
  assign acc_wr   = (state_q == ST_IDLE) ? avm_write   : is_wr_q;

  // Read value captured on entry to ACK; unmapped and TX-data reads return zero.
  always_comb begin
    rd_next = '0;
    case (acc_addr)
      ADDR_RX:   if (rx_nonempty) rd_next = {24'b0, rx_head};
      ADDR_STAT: rd_next = {24'b0, rx_nonempty, tx_not_full, 4'b0000, rx_underrun_q, tx_overrun_q};
      default:   rd_next = '0;
    endcase
  end

  // FIFO controls: a same-cycle pop frees room for a push even when full.
  assign rx_pop  = ack_exit && rx_pop_pend_q;
  assign rx_push = rx_in_valid && (!rx_full || rx_pop);
  assign tx_pop  = tx_out_valid && tx_out_ready;
  assign tx_wr   = ack_exit && is_wr_q && (addr_q == ADDR_TX);
  assign tx_push = tx_wr && (!tx_full || tx_pop);
  assign tx_drop = tx_wr && !tx_push;

  // Bus FSM state, access latch, read data and deferred side-effect flags.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      is_wr_q       <= 1'b0;
      avm_readdata  <= '0;
      rx_pop_pend_q <= 1'b0;
      ur_pend_q     <= 1'b0;
      clr_pend_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if ((state_q == ST_IDLE) && (avm_read || avm_write)) begin
        addr_q  <= avm_address;
        is_wr_q <= avm_write;
      end
      if (load_en) begin
        if (!acc_wr) avm_readdata <= rd_next;
        rx_pop_pend_q <= !acc_wr && (acc_addr == ADDR_RX) && rx_nonempty;
        ur_pend_q     <= !acc_wr && (acc_addr == ADDR_RX) && !rx_nonempty;
        clr_pend_q    <= !acc_wr && (acc_addr == ADDR_STAT);
      end else if (ack_exit) begin
        rx_pop_pend_q <= 1'b0;
        ur_pend_q     <= 1'b0;
        clr_pend_q    <= 1'b0;
      end
    end
  end

  // Sticky error flags: a set in the same cycle as a status-read clear takes priority.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      rx_underrun_q <= 1'b0;
      tx_overrun_q  <= 1'b0;
    end else begin
      if (ack_exit && ur_pend_q)       rx_underrun_q <= 1'b1;
      else if (ack_exit && clr_pend_q) rx_underrun_q <= 1'b0;
      if (tx_drop)                     tx_overrun_q  <= 1'b1;
      else if (ack_exit && clr_pend_q) tx_overrun_q  <= 1'b0;
    end
  end

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .avm_clk (avm_clk),
    .avm_rst (avm_rst),
    .push    (rx_push),
    .pop     (rx_pop),
    .wdata   (rx_in_data),
    .rdata   (rx_head),
    .count   (rx_count)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .avm_clk (avm_clk),
    .avm_rst (avm_rst),
    .push    (tx_push),
    .pop     (tx_pop),
    .wdata   (avm_writedata[7:0]),
    .rdata   (tx_head),
    .count   (tx_count)
  );

  assign rx_in_ready  = !rx_full;
  assign tx_out_valid = (tx_count != '0);
  assign tx_out_data  = tx_head;
endmodule
